// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a 1-cycle-latency async FIFO read port into a valid/ready stream.
// Define FIFO_READER_CNT_EN to add the 16-bit delivered-beat counter count_o.
module fifo_stream_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk_rd,
    input  logic             rst_n,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_read_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      count_o
`endif
);
    logic [WIDTH-1:0] buffer [2];
    logic [1:0] occ;
    logic [1:0] level;
    logic inflight;
    logic head;
    logic tail;
    logic pop;
    assign level = occ + {1'b0, inflight};
    assign m_valid_o = occ != 2'd0;
    assign pop = m_valid_o && m_ready_i;
    assign m_data_o = buffer[head];
    // a pop may be issued into a full pipeline only when a word leaves the same cycle
    assign fifo_rd_en_o = rst_n && !fifo_empty_i && (level < 2'd2 || (level == 2'd2 && pop));
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head      <= 1'b0;
            tail      <= 1'b0;
            buffer[0] <= '0;
            buffer[1] <= '0;
        end else begin
            inflight <= fifo_rd_en_o;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            if (inflight) begin
                buffer[tail] <= fifo_read_data_i;
                tail         <= ~tail;
            end
            if (pop)
                head <= ~head;
        end
    end
`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n)
            count_o <= 16'd0;
        else if (pop)
            count_o <= count_o + 16'd1;
    end
`endif
endmodule
